cmd_writer: RTL
===============

CMD_WRITER -- requirements
Module: cmd_writer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the cs synchronizer (minimum 2).
REQ-002 Port clk, input, 1: core clock shared with the frame buffer and VGA path.
REQ-003 Port resetB, input, 1: reset, asynchronous and active-low.
REQ-004 Port cs, input, 1: SPI chip-select from the pad, asynchronous to clk, active-high during a transfer.
REQ-005 Port command, input, 8: SPI byte 0, bits [7:4] opcode and bits [1:0] address/score high bits; stable from cs fall until the next cs rise.
REQ-006 Ports databyte1 and databyte2, input, 8 each: SPI bytes 1 and 2; same stability rule as command.
REQ-007 Port we, output, 1: frame-buffer write strobe.
REQ-008 Port waddr, output, 10: frame-buffer write address.
REQ-009 Port wdata, output, 8: frame-buffer write data.
REQ-010 Port state, output, 16: game state word to the VGA path.
REQ-011 Port score, output, 10: score to the VGA path.
REQ-012 Port busy, output, 1: high while a multi-cycle command runs.
REQ-013 Port drop, output, 1: one-cycle pulse when a command is discarded.

Function
REQ-014 cs SHALL pass through a SYNC_STAGES-flop synchronizer; the end of a transaction is the cycle E in which synchronized cs is low and was high in the previous cycle.
REQ-015 In cycle E, if FSM is IDLE, command, databyte1 and databyte2 SHALL be captured into internal registers at the end of E.
REQ-016 FSM states SHALL be IDLE, EXEC, FILL; IDLE->EXEC on capture; EXEC->IDLE after one cycle, or EXEC->FILL for opcode FILL; FILL->IDLE after the address-1023 write.
REQ-017 Opcode 0x1 WRITE: in cycle E+1, we=1, waddr={command[1:0],databyte1}, wdata=databyte2, for exactly one cycle.
REQ-018 Opcode 0x2 FILL: cycles E+1..E+1024, we=1, wdata=databyte2, waddr counts 0..1023 incrementing by 1 per cycle; busy=1 from E+1 through E+1024 inclusive.
REQ-019 Opcode 0x3 SET_STATE: state={databyte1,databyte2}, registered and visible from cycle E+1; we stays 0.
REQ-020 Opcode 0x4 SET_SCORE: score={command[1:0],databyte2}, visible from E+1; we stays 0.
REQ-021 Any other opcode SHALL be ignored except that drop pulses in E+1.
REQ-022 A transaction end detected while busy=1 SHALL be discarded: no capture, FILL continues unaffected, drop=1 in cycle E+1.
REQ-023 Outside the cycles listed above, we=0; waddr and wdata hold their last value.
REQ-024 The waddr counter SHALL NOT wrap past 1023; FILL terminates there.

Reset
REQ-025 While resetB=0: we=0, waddr=0, wdata=0, state=0, score=0, busy=0, drop=0, FSM=IDLE, all synchronizer flops=0.
REQ-026 Reset asserted mid-FILL SHALL abort it immediately; no write occurs after reset release until a new transaction end.
REQ-027 A synchronized cs that is already low at reset release SHALL NOT produce a transaction end.

Configuration
REQ-028 Macro CMD_FILL_EN: when defined, FILL behaves per REQ-018; when undefined, opcode 0x2 is treated as unknown (REQ-021), the FILL state and address counter are not built, and busy is tied to 0.

Structure
REQ-029 Shared package snake_pkg SHALL hold the opcode enum (OP_WRITE=0x1, OP_FILL=0x2, OP_SET_STATE=0x3, OP_SET_SCORE=0x4), the FSM state typedef, and the constants FB_ADDR_W=10, FB_DEPTH=1024, STATE_W=16, SCORE_W=10.
REQ-030 The cs synchronizer SHALL be a separate sub-module, sync_ff, parameterized by stage count.

Verification
REQ-031 Bench: command=0x13, databyte1=0x45, databyte2=0xA7, then drop cs -> one we pulse, waddr=0x345, wdata=0xA7, exactly SYNC_STAGES+1 clk after the cs fall.
REQ-032 Bench: command=0x20, databyte2=0x5C (CMD_FILL_EN defined) -> 1024 consecutive we cycles, waddr 0..1023, wdata=0x5C, busy high for those cycles only; with the macro undefined -> drop pulse and no writes.
REQ-033 Bench: SET_STATE with 0x12,0x34, then SET_SCORE with command=0x42, databyte2=0x10 -> state=0x1234, then score=0x210; we never asserted.
REQ-034 Bench: WRITE transaction ending at fill address 500 -> drop pulse, fill completes through 1023 unchanged, WRITE not performed.
REQ-035 Bench: resetB low at fill address 300 -> all outputs 0 within the same cycle; after release no we until a new cs fall; cs held low across release -> no transaction.
REQ-036 Bench: opcode 0xF0 -> single drop pulse; state, score and we unchanged.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the command writer.
// CMD_FILL_EN adds the FILL state to the FSM encoding.
package snake_pkg;

    localparam int unsigned FB_ADDR_W = 10;
    localparam int unsigned FB_DEPTH  = 1024;
    localparam int unsigned STATE_W   = 16;
    localparam int unsigned SCORE_W   = 10;

    typedef enum logic [3:0] {
        OP_WRITE     = 4'h1,
        OP_FILL      = 4'h2,
        OP_SET_STATE = 4'h3,
        OP_SET_SCORE = 4'h4
    } opcode_e;

`ifdef CMD_FILL_EN
    typedef enum logic [1:0] {StIdle, StExec, StFill} fsm_e;
`else
    typedef enum logic [1:0] {StIdle, StExec} fsm_e;
`endif

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cmd_writer.sv
// Decodes SPI command bytes at the end of each cs transaction into frame-buffer writes and
// state/score updates. Define CMD_FILL_EN to build the frame-buffer FILL command.
module cmd_writer
    import snake_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetB,
    input  logic                 cs,
    input  logic [7:0]           command,
    input  logic [7:0]           databyte1,
    input  logic [7:0]           databyte2,
    output logic                 we,
    output logic [FB_ADDR_W-1:0] waddr,
    output logic [7:0]           wdata,
    output logic [STATE_W-1:0]   state,
    output logic [SCORE_W-1:0]   score,
    output logic                 busy,
    output logic                 drop
);

    logic cs_sync, cs_prev_q, txn_end;
    fsm_e fsm_q, fsm_d;
    logic we_q, we_d, drop_q, drop_d;
    logic [FB_ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic unused_cmd;

`ifdef CMD_FILL_EN
    logic busy_q, busy_d;
    logic [3:0] op_q, op_d;
`endif

    sync_ff #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (clk),
        .rst_ni (resetB),
        .d_i    (cs),
        .q_o    (cs_sync)
    );

    // cs_prev_q resets low, so cs already low at release never looks like a falling edge
    assign txn_end    = cs_prev_q & ~cs_sync;
    assign unused_cmd = ^command[3:2];

    always_comb begin
        fsm_d   = fsm_q;
        we_d    = 1'b0;
        drop_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        state_d = state_q;
        score_d = score_q;
`ifdef CMD_FILL_EN
        busy_d  = busy_q;
        op_d    = op_q;
`endif
        if (txn_end && fsm_q != StIdle) begin
            drop_d = 1'b1;
        end
        case (fsm_q)
            StIdle: begin
                if (txn_end) begin
                    fsm_d = StExec;
`ifdef CMD_FILL_EN
                    op_d  = command[7:4];
`endif
                    // Results are registered at the end of E so they appear in E+1
                    case (command[7:4])
                        OP_WRITE: begin
                            we_d    = 1'b1;
                            waddr_d = {command[1:0], databyte1};
                            wdata_d = databyte2;
                        end
`ifdef CMD_FILL_EN
                        OP_FILL: begin
                            we_d    = 1'b1;
                            waddr_d = '0;
                            wdata_d = databyte2;
                            busy_d  = 1'b1;
                        end
`endif
                        OP_SET_STATE: state_d = {databyte1, databyte2};
                        OP_SET_SCORE: score_d = {command[1:0], databyte2};
                        default:      drop_d  = 1'b1;
                    endcase
                end
            end
            StExec: begin
                fsm_d = StIdle;
`ifdef CMD_FILL_EN
                if (op_q == OP_FILL) begin
                    fsm_d   = StFill;
                    we_d    = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
`endif
            end
`ifdef CMD_FILL_EN
            StFill: begin
                if (waddr_q == FB_ADDR_W'(FB_DEPTH - 1)) begin
                    fsm_d  = StIdle;
                    busy_d = 1'b0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
            end
`endif
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            fsm_q     <= StIdle;
            cs_prev_q <= 1'b0;
            we_q      <= 1'b0;
            drop_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            state_q   <= '0;
            score_q   <= '0;
`ifdef CMD_FILL_EN
            busy_q    <= 1'b0;
            op_q      <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            cs_prev_q <= cs_sync;
            we_q      <= we_d;
            drop_q    <= drop_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            state_q   <= state_d;
            score_q   <= score_d;
`ifdef CMD_FILL_EN
            busy_q    <= busy_d;
            op_q      <= op_d;
`endif
        end
    end

    assign we    = we_q;
    assign drop  = drop_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign state = state_q;
    assign score = score_q;
`ifdef CMD_FILL_EN
    assign busy  = busy_q;
`else
    assign busy  = 1'b0;
`endif

endmodule
